// File: rtl/cmp_pkg.sv
// Shared encodings for seq_magnitude_comparator: result codes, FSM states and
// the cascade-priority resolution used when every slice compares equal.
package cmp_pkg;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_LT   = 3'b010;
    localparam logic [2:0] CMP_EQ   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;

    // Cascade {gt,lt,eq} with priority gt > lt > eq; an all-zero cascade means plain equality.
    function automatic logic [2:0] resolve_cascade(input logic [2:0] casc);
        if (casc[2]) return CMP_GT;
        if (casc[1]) return CMP_LT;
        return CMP_EQ;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Start/done handshake plus operand/result bus of seq_magnitude_comparator.
// Defining CMP_SIGNED_EN adds the iSigned operand-mode signal.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16
);
    logic             iStart;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic [2:0]       iData;
`ifdef CMP_SIGNED_EN
    logic             iSigned;
`endif
    logic [2:0]       oData;
    logic             oBusy;
    logic             oDone;

`ifdef CMP_SIGNED_EN
    modport master (output iStart, iData_a, iData_b, iData, iSigned,
                    input  oData, oBusy, oDone);
    modport slave  (input  iStart, iData_a, iData_b, iData, iSigned,
                    output oData, oBusy, oDone);
`else
    modport master (output iStart, iData_a, iData_b, iData,
                    input  oData, oBusy, oDone);
    modport slave  (input  iStart, iData_a, iData_b, iData,
                    output oData, oBusy, oDone);
`endif

endinterface

// File: rtl/cmp_slice.sv
// Combinational unsigned comparison of one SLICE-bit operand slice.
module cmp_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, one SLICE per clock with early exit.
// Optional signed mode is compiled in with CMP_SIGNED_EN.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                       iClk,
    input  logic                       iRst,
    seq_magnitude_comparator_if.slave  cmp_if
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

    cmp_state_t       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       casc_q;
    logic [2:0]       res_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
`ifdef CMP_SIGNED_EN
    logic             signed_q;
`endif

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic             s_gt;
    logic             s_lt;
    logic             s_eq;

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (idx_q == IDX_W'(s)) begin
                sl_a = a_q[s*SLICE +: SLICE];
                sl_b = b_q[s*SLICE +: SLICE];
            end
        end
`ifdef CMP_SIGNED_EN
        // Flipping both sign bits maps two's-complement order onto unsigned order.
        if (signed_q && (idx_q == IDX_TOP)) begin
            sl_a[SLICE-1] = ~sl_a[SLICE-1];
            sl_b[SLICE-1] = ~sl_b[SLICE-1];
        end
`endif
    end

    cmp_slice #(.SLICE(SLICE)) u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .gt (s_gt),
        .lt (s_lt),
        .eq (s_eq)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            casc_q   <= '0;
            idx_q    <= '0;
            res_q    <= CMP_NONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CMP_SIGNED_EN
            signed_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (cmp_if.iStart) begin
                        a_q      <= cmp_if.iData_a;
                        b_q      <= cmp_if.iData_b;
                        casc_q   <= cmp_if.iData;
`ifdef CMP_SIGNED_EN
                        signed_q <= cmp_if.iSigned;
`endif
                        idx_q    <= IDX_TOP;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    if (!s_eq) begin
                        res_q   <= {s_gt, s_lt, 1'b0};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (idx_q != '0) begin
                        idx_q   <= idx_q - 1'b1;
                    end else begin
                        res_q   <= resolve_cascade(casc_q);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmp_if.oData = res_q;
    assign cmp_if.oBusy = busy_q;
    assign cmp_if.oDone = done_q;

endmodule
